scaler_coeff_gen: RTL and testbench

SCALER_COEFF_GEN -- requirements
Module: scaler_coeff_gen

---
 rtl/scaler_coeff_gen_if.sv | 33 +++
 rtl/scaler_coeff_gen.sv | 177 +++++++++++++++++
 tb/tb_scaler_coeff_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_coeff_gen_if.sv
// Control/configuration and coefficient-output bundle for the scaler coefficient generator.
// The master side drives line configuration; the slave side is the generator itself.
interface scaler_coeff_gen_if #(
    parameter int PHASE_W = 8,
    parameter int CNT_W   = 11
);
    logic               start_i;
    logic               en_i;
    logic               mode_i;
    logic [PHASE_W:0]   step_i;
    logic [CNT_W-1:0]   in_len_i;
    logic [CNT_W-1:0]   out_len_i;
    logic [1:0]         inopcode_o;
    logic [1:0]         calcopcode_o;
    logic [PHASE_W-1:0] coeff_b0_o;
    logic [PHASE_W-1:0] coeff_b1_o;
    logic               pix_adv_o;
    logic               valid_o;
    logic               busy_o;
    logic               line_done_o;

    modport master (
        output start_i, en_i, mode_i, step_i, in_len_i, out_len_i,
        input  inopcode_o, calcopcode_o, coeff_b0_o, coeff_b1_o,
               pix_adv_o, valid_o, busy_o, line_done_o
    );

    modport slave (
        input  start_i, en_i, mode_i, step_i, in_len_i, out_len_i,
        output inopcode_o, calcopcode_o, coeff_b0_o, coeff_b1_o,
               pix_adv_o, valid_o, busy_o, line_done_o
    );
endinterface

// File: rtl/scaler_coeff_gen.sv
// Per-output-pixel phase accumulator producing 2-tap interpolation weights and MAC opcodes.
// Every output is registered: the action for a cycle is decided at the preceding rising edge.
module scaler_coeff_gen #(
    parameter int PHASE_W = 8,
    parameter int CNT_W   = 11
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    scaler_coeff_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [PHASE_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]   out_cnt_reg, out_cnt_next;
    logic [CNT_W-1:0]   fetch_cnt_reg, fetch_cnt_next;
    logic               mode_reg, mode_next;
    logic [PHASE_W:0]   step_reg, step_next;
    logic [CNT_W-1:0]   in_len_reg, in_len_next;
    logic [CNT_W-1:0]   out_len_reg, out_len_next;
    logic [1:0]         inop_reg, inop_next;
    logic [1:0]         calc_reg, calc_next;
    logic [PHASE_W-1:0] b0_reg, b0_next;
    logic [PHASE_W-1:0] b1_reg, b1_next;
    logic               pix_reg, pix_next;
    logic               valid_reg, valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [PHASE_W-1:0] frac;
    logic [PHASE_W-1:0] frac_inv;
    logic [PHASE_W:0]   phase_sum;
    logic               carry;
    logic               can_fetch;
    logic               start_ok;
    logic               run_step;

    assign frac      = acc_reg;
    assign phase_sum = {1'b0, frac} + step_reg;
    assign carry     = phase_sum[PHASE_W];
    assign can_fetch = (fetch_cnt_reg < in_len_reg);
    assign start_ok  = bus.start_i && (bus.out_len_i != '0) && (bus.in_len_i >= CNT_W'(2));

    // Older-pixel weight is the one's complement, so the pair always sums to 2^PHASE_W-1.
    genvar gi;
    generate
        for (gi = 0; gi < PHASE_W; gi++) begin : g_inv
            assign frac_inv[gi] = ~frac[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        out_cnt_next   = out_cnt_reg;
        fetch_cnt_next = fetch_cnt_reg;
        mode_next      = mode_reg;
        step_next      = step_reg;
        in_len_next    = in_len_reg;
        out_len_next   = out_len_reg;
        calc_next      = calc_reg;
        b0_next        = b0_reg;
        b1_next        = b1_reg;
        busy_next      = busy_reg;
        inop_next      = 2'b00;
        pix_next       = 1'b0;
        valid_next     = 1'b0;
        done_next      = 1'b0;
        run_step       = 1'b0;

        if (bus.en_i) begin
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        mode_next      = bus.mode_i;
                        step_next      = (bus.step_i == '0) ? (PHASE_W+1)'(1) : bus.step_i;
                        in_len_next    = bus.in_len_i;
                        out_len_next   = bus.out_len_i;
                        acc_next       = '0;
                        out_cnt_next   = '0;
                        // The first priming fetch is issued right away to meet the t+1 latency.
                        fetch_cnt_next = CNT_W'(1);
                        pix_next       = 1'b1;
                        inop_next      = 2'b10;
                        busy_next      = 1'b1;
                        state_next     = PRIME;
                    end
                end
                PRIME: begin
                    if (fetch_cnt_reg < CNT_W'(2)) begin
                        fetch_cnt_next = fetch_cnt_reg + CNT_W'(1);
                        pix_next       = 1'b1;
                        inop_next      = 2'b10;
                    end else begin
                        state_next = RUN;
                        run_step   = 1'b1;
                    end
                end
                RUN: begin
                    if (out_cnt_reg == out_len_reg) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        run_step = 1'b1;
                    end
                end
                DONE: begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end

        if (run_step) begin
            valid_next   = 1'b1;
            b0_next      = frac;
            b1_next      = frac_inv;
            calc_next    = mode_reg ? (frac[PHASE_W-1] ? 2'b01 : 2'b10) : 2'b00;
            acc_next     = phase_sum[PHASE_W-1:0];
            out_cnt_next = out_cnt_reg + CNT_W'(1);
            // Without a carry, or once the line is exhausted, the newest pixel is reused.
            if (carry && can_fetch) begin
                fetch_cnt_next = fetch_cnt_reg + CNT_W'(1);
                pix_next       = 1'b1;
                inop_next      = 2'b10;
            end
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            out_cnt_reg   <= '0;
            fetch_cnt_reg <= '0;
            mode_reg      <= 1'b0;
            step_reg      <= '0;
            in_len_reg    <= '0;
            out_len_reg   <= '0;
            inop_reg      <= 2'b00;
            calc_reg      <= 2'b00;
            b0_reg        <= '0;
            b1_reg        <= '0;
            pix_reg       <= 1'b0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            out_cnt_reg   <= out_cnt_next;
            fetch_cnt_reg <= fetch_cnt_next;
            mode_reg      <= mode_next;
            step_reg      <= step_next;
            in_len_reg    <= in_len_next;
            out_len_reg   <= out_len_next;
            inop_reg      <= inop_next;
            calc_reg      <= calc_next;
            b0_reg        <= b0_next;
            b1_reg        <= b1_next;
            pix_reg       <= pix_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign bus.inopcode_o   = inop_reg;
    assign bus.calcopcode_o = calc_reg;
    assign bus.coeff_b0_o   = b0_reg;
    assign bus.coeff_b1_o   = b1_reg;
    assign bus.pix_adv_o    = pix_reg;
    assign bus.valid_o      = valid_reg;
    assign bus.busy_o       = busy_reg;
    assign bus.line_done_o  = done_reg;
endmodule

// File: tb/tb_scaler_coeff_gen.sv
// Self-checking bench: directed and randomized lines compared cycle-by-cycle
// against an arithmetic model of the expected per-cycle output events.
module tb_scaler_coeff_gen;
    localparam int PHASE_W = 8;
    localparam int CNT_W   = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scaler_coeff_gen_if #(.PHASE_W(PHASE_W), .CNT_W(CNT_W)) bus ();
    scaler_coeff_gen #(.PHASE_W(PHASE_W), .CNT_W(CNT_W)) dut (
        .CLK_i (clk),
        .RST_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic       valid;
        logic       pix;
        logic       done;
        logic       busy;
        logic [1:0] inop;
        logic [1:0] calc;
        logic [7:0] b0;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_fetch;
    int  last_b0 = 0;
    int  last_b1 = 0;
    int  last_busy = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected event per enabled cycle: 2 prime fetches, out_len outputs, done pulse, idle.
    task automatic build_line(input int step, input int mode, input int in_len, input int out_len);
        ev_t e;
        int  s, fetched, phase;
        bit  fetch;
        exp_q.delete();
        s = (step == 0) ? 1 : step;
        fetched = 2;
        e = '0; e.pix = 1'b1; e.inop = 2'b10; e.busy = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int j = 0; j < out_len; j++) begin
            phase = (j * s) % 256;
            fetch = ((phase + s) >= 256) && (fetched < in_len);
            if (fetch) fetched++;
            e = '0;
            e.valid = 1'b1; e.busy = 1'b1; e.pix = fetch;
            e.inop = fetch ? 2'b10 : 2'b00;
            e.b0 = 8'(phase);
            e.calc = (mode == 0) ? 2'b00 : ((phase >= 128) ? 2'b01 : 2'b10);
            exp_q.push_back(e);
        end
        e = '0; e.done = 1'b1; e.busy = 1'b1;
        exp_q.push_back(e);
        e = '0;
        exp_q.push_back(e);
        exp_fetch = fetched;
    endtask

    task automatic check_event(input ev_t e);
        chk("valid", 32'(bus.valid_o), 32'(e.valid));
        chk("pix_adv", 32'(bus.pix_adv_o), 32'(e.pix));
        chk("inopcode", 32'(bus.inopcode_o), 32'(e.inop));
        chk("line_done", 32'(bus.line_done_o), 32'(e.done));
        chk("busy", 32'(bus.busy_o), 32'(e.busy));
        if (e.valid) begin
            last_b0 = int'(e.b0);
            last_b1 = 255 - int'(e.b0);
            chk("calcopcode", 32'(bus.calcopcode_o), 32'(e.calc));
        end
        chk("coeff_b0", 32'(bus.coeff_b0_o), 32'(last_b0));
        chk("coeff_b1", 32'(bus.coeff_b1_o), 32'(last_b1));
        last_busy = int'(e.busy);
    endtask

    task automatic check_stall();
        chk("stall_valid", 32'(bus.valid_o), 32'(0));
        chk("stall_pix_adv", 32'(bus.pix_adv_o), 32'(0));
        chk("stall_inopcode", 32'(bus.inopcode_o), 32'(0));
        chk("stall_line_done", 32'(bus.line_done_o), 32'(0));
        chk("stall_busy", 32'(bus.busy_o), 32'(last_busy));
        chk("stall_coeff_b0", 32'(bus.coeff_b0_o), 32'(last_b0));
        chk("stall_coeff_b1", 32'(bus.coeff_b1_o), 32'(last_b1));
    endtask

    task automatic run_line(input int step, input int mode, input int in_len, input int out_len,
                            input int en_pct, input int stall_at, input int stall_len, input bit noise);
        ev_t e;
        bit  en_prev;
        int  cyc, budget, nval, npix;
        build_line(step, mode, in_len, out_len);
        $display("line: step=%0d mode=%0d in_len=%0d out_len=%0d en_pct=%0d stall=%0d/%0d noise=%0d",
                 step, mode, in_len, out_len, en_pct, stall_at, stall_len, noise);
        bus.step_i = (PHASE_W+1)'(step);
        bus.mode_i = mode[0];
        bus.in_len_i = CNT_W'(in_len);
        bus.out_len_i = CNT_W'(out_len);
        bus.start_i = 1'b1;
        bus.en_i = 1'b1;
        @(posedge clk); #1;
        en_prev = 1'b1;
        cyc = 0; nval = 0; npix = 0;
        budget = 8 * (out_len + 6) + 60;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (en_prev) begin
                e = exp_q.pop_front();
                check_event(e);
            end else begin
                check_stall();
            end
            if (bus.valid_o === 1'b1) nval++;
            if (bus.pix_adv_o === 1'b1) npix++;
            if (exp_q.size() == 0) break;
            bus.start_i = noise;
            if (noise) begin
                bus.step_i = (PHASE_W+1)'($urandom_range(0, 256));
                bus.mode_i = 1'($urandom_range(0, 1));
                bus.in_len_i = CNT_W'($urandom_range(2, 9));
                bus.out_len_i = CNT_W'($urandom_range(1, 9));
            end
            if (stall_len > 0)
                bus.en_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
            else if (en_pct < 100)
                bus.en_i = ($urandom_range(0, 99) < en_pct);
            else
                bus.en_i = 1'b1;
            @(posedge clk); #1;
            en_prev = bus.en_i;
            cyc++;
        end
        chk("events_left", 32'(exp_q.size()), 32'(0));
        chk("valid_count", 32'(nval), 32'(out_len));
        chk("pix_adv_count", 32'(npix), 32'(exp_fetch));
        bus.start_i = 1'b0;
        bus.en_i = 1'b1;
        @(posedge clk); #1;
        chk("post_idle_busy", 32'(bus.busy_o), 32'(0));
        chk("post_idle_valid", 32'(bus.valid_o), 32'(0));
    endtask

    task automatic reject_start(input int in_len, input int out_len);
        bus.step_i = 9'd64;
        bus.mode_i = 1'b0;
        bus.in_len_i = CNT_W'(in_len);
        bus.out_len_i = CNT_W'(out_len);
        bus.start_i = 1'b1;
        bus.en_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        $display("reject: in_len=%0d out_len=%0d busy=%0b pix_adv=%0b",
                 in_len, out_len, bus.busy_o, bus.pix_adv_o);
        chk("reject_busy", 32'(bus.busy_o), 32'(0));
        chk("reject_pix_adv", 32'(bus.pix_adv_o), 32'(0));
        @(posedge clk); #1;
        chk("reject_valid", 32'(bus.valid_o), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.en_i = 1'b1;
        bus.mode_i = 1'b1;
        bus.step_i = 9'd128;
        bus.in_len_i = 11'd4;
        bus.out_len_i = 11'd8;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: busy=%0b valid=%0b pix_adv=%0b line_done=%0b", bus.busy_o, bus.valid_o,
                 bus.pix_adv_o, bus.line_done_o);
        chk("rst_busy", 32'(bus.busy_o), 32'(0));
        chk("rst_valid", 32'(bus.valid_o), 32'(0));
        chk("rst_pix_adv", 32'(bus.pix_adv_o), 32'(0));
        chk("rst_line_done", 32'(bus.line_done_o), 32'(0));
        chk("rst_inopcode", 32'(bus.inopcode_o), 32'(0));
        chk("rst_calcopcode", 32'(bus.calcopcode_o), 32'(0));
        chk("rst_coeff_b0", 32'(bus.coeff_b0_o), 32'(0));
        chk("rst_coeff_b1", 32'(bus.coeff_b1_o), 32'(0));
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;

        run_line(128, 0, 4, 8, 100, 0, 0, 1'b0);
        run_line(64, 1, 4, 4, 100, 0, 0, 1'b0);
        run_line(256, 0, 5, 5, 100, 0, 0, 1'b0);
        run_line(0, 1, 3, 4, 100, 0, 0, 1'b0);
        run_line(96, 1, 6, 10, 100, 6, 3, 1'b0);
        run_line(200, 0, 3, 12, 100, 0, 0, 1'b1);
        run_line(1, 0, 2, 1, 100, 0, 0, 1'b0);
        for (int k = 0; k < 8; k++)
            run_line($urandom_range(0, 256), $urandom_range(0, 1), $urandom_range(2, 30),
                     $urandom_range(1, 30), 75, 0, 0, k[0]);

        reject_start(4, 0);
        reject_start(1, 6);

        // Abort a line mid-RUN; reset must win over a concurrent start.
        bus.step_i = 9'd100;
        bus.mode_i = 1'b0;
        bus.in_len_i = 11'd5;
        bus.out_len_i = 11'd20;
        bus.start_i = 1'b1;
        bus.en_i = 1'b1;
        @(posedge clk); #1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        $display("abort: busy=%0b valid=%0b line_done=%0b", bus.busy_o, bus.valid_o, bus.line_done_o);
        chk("abort_busy", 32'(bus.busy_o), 32'(0));
        chk("abort_valid", 32'(bus.valid_o), 32'(0));
        chk("abort_line_done", 32'(bus.line_done_o), 32'(0));
        chk("abort_coeff_b0", 32'(bus.coeff_b0_o), 32'(0));
        chk("abort_pix_adv", 32'(bus.pix_adv_o), 32'(0));
        rst = 1'b0;
        bus.start_i = 1'b0;
        last_b0 = 0; last_b1 = 0; last_busy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_after_line_done", 32'(bus.line_done_o), 32'(0));
            chk("abort_after_busy", 32'(bus.busy_o), 32'(0));
        end

        run_line(128, 0, 4, 8, 100, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
